sram_resp_confreg: RTL and testbench
====================================

// Module: sram_resp_confreg
// PURPOSE
//  Responder for the core's SRAM-style data port (en/we/addr/wdata -> rdata).
//  Services loads and stores with a fixed 1-cycle read latency from an internal word RAM.
//  Decodes a small MMIO window of configuration registers: LED, switch, scratch, write counter, optional timer.
//  Sits outside mycpu_top, directly on its data_sram_* pins; this is the block the bench and SoC top instantiate.
// PARAMETERS
//  ADDR_W     12             word-index bits of RAM (2^ADDR_W words, 16 KB at default)
//  MMIO_BASE  32'hbfaf_0000  base address of the MMIO window
//  MMIO_MASK  32'hffff_0000  address bits compared against MMIO_BASE
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  resetn       in   1   asynchronous, active-low reset
//  sram_en      in   1   access request this cycle
//  sram_we      in   4   byte write enables; 4'b0000 = read
//  sram_addr    in   32  byte address; bits [1:0] ignored
//  sram_wdata   in   32  write data, byte lane i = bits [8i+7:8i]
//  sram_rdata   out  32  read data, valid the cycle after sram_en
//  led          out  16  LED register contents
//  switch_in    in   8   asynchronous switch inputs
// BEHAVIOUR
//  - Decode: mmio_hit = ((sram_addr & MMIO_MASK) == MMIO_BASE); otherwise RAM, index sram_addr[ADDR_W+1:2] (aliases).
//  - Read latency 1: on posedge with sram_en=1, sram_rdata <= selected word; with sram_en=0, sram_rdata holds.
//  - Read-first: when sram_en=1 and sram_we!=0, sram_rdata gets the pre-write word; byte lanes with we[i]=1 update.
//  - Write on posedge only when sram_en=1; sram_we ignored when sram_en=0.
//  - MMIO offsets (sram_addr[15:0]):
//    - 0x00 LED: rw, low 16 bits, byte-enabled; reads zero-extended.
//    - 0x04 SWITCH: ro, 2-flop synchronised switch_in, zero-extended.
//    - 0x08 SCRATCH: rw 32, byte-enabled.
//    - 0x0C TIMER: see CONFIGURATION.
//    - 0x10 WCOUNT: ro 32, +1 per RAM write (any we!=0), wraps 0xffff_ffff->0; MMIO writes don't count.
//    - Other offsets read 0; writes are ignored.
//  - Reset (async, any cycle, including mid-access): sram_rdata=0, led=0, SCRATCH=0, WCOUNT=0, TIMER=0, sync flops=0.
//    - RAM contents are not reset.
//    - An access in flight at reset is dropped.
//    - The first access after resetn rises behaves normally.
//  - Simultaneous events: a same-cycle write to SCRATCH/LED and read of it returns the old value (read-first).
//  - A TIMER write beats the increment.
//  - Back-to-back accesses allowed every cycle; no stall, no backpressure.
// CONFIGURATION
//  SRAM_RESP_TIMER_EN defined:
//    - TIMER is a 32-bit free-running counter, +1 every cycle, wraps to 0.
//    - A write (we=4'b1111 only; partial writes ignored) loads wdata; the next cycle shows wdata+1.
//    - A read returns the value at the access posedge.
//  SRAM_RESP_TIMER_EN undefined:
//    - No counter logic; TIMER reads 0 and writes are ignored.
// TESTING
//  1. Write 0xdeadbeef @0x1c000100 (we=f), then read the same address -> rdata=0xdeadbeef one cycle after en.
//  2. Byte write we=4'b0010 wdata=0x0000aa00 to the word from test 1 -> read gives 0xdeadaaef.
//  3. Read-during-write: en=1, we=f, wdata=0x11111111 on a word holding 0x22222222 -> next-cycle rdata=0x22222222;
//     following read gives 0x11111111.
//  4. MMIO:
//     - write 0x0001abcd to MMIO_BASE+0 -> led=0xabcd, readback 0x0000abcd;
//     - switch_in=0x5a -> 0x0000005a at +4 within 3 cycles;
//     - read at +0x20 -> 0.
//  5. Counters:
//     - 3 RAM writes then read +0x10 -> 3;
//     - with TIMER_EN, write 0xffff_fffe to +0x0C, read two cycles later -> 0x0000_0000 (wrap);
//     - without TIMER_EN -> 0.
//  6. Reset: assert resetn=0 mid-read with led=0xabcd -> sram_rdata=0 and led=0 immediately (async);
//     after release, RAM word from test 1 still reads back its last value.

Source files
------------

// File: rtl/sram_resp_confreg.sv
// sram_resp_confreg: data-port responder for the core's SRAM-style bus.
//   - word RAM of 2^ADDR_W entries, 1-cycle read-first latency, byte writes
//   - MMIO window at MMIO_BASE: LED, SWITCH, SCRATCH, TIMER, WCOUNT
// Optional feature macro: SRAM_RESP_TIMER_EN (free-running TIMER at +0x0C).
// Without it TIMER reads 0 and writes to it are dropped.
module sram_resp_confreg #(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] MMIO_BASE = 32'hbfaf_0000,
    parameter logic [31:0] MMIO_MASK = 32'hffff_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sram_en,
    input  logic [3:0]  sram_we,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    output logic [15:0] led,
    input  logic [7:0]  switch_in
);

    localparam logic [15:0] OFF_LED    = 16'h0000;
    localparam logic [15:0] OFF_SWITCH = 16'h0004;
    localparam logic [15:0] OFF_SCR    = 16'h0008;
    localparam logic [15:0] OFF_TIMER  = 16'h000c;
    localparam logic [15:0] OFF_WCOUNT = 16'h0010;

    logic [31:0]       r_mem [0:(1<<ADDR_W)-1];
    logic [31:0]       r_rdata;
    logic [15:0]       r_led;
    logic [31:0]       r_scratch;
    logic [31:0]       r_wcount;
    logic [7:0]        r_sw1;
    logic [7:0]        r_sw2;

    logic              w_mmio_hit;
    logic [ADDR_W-1:0] w_idx;
    logic [15:0]       w_off;
    logic              w_ram_wr;
    logic              w_mmio_wr;
    logic [31:0]       w_mem_word;
    logic [31:0]       w_timer_rd;
    logic [31:0]       w_rd_word;

    assign w_mmio_hit = ((sram_addr & MMIO_MASK) == MMIO_BASE);
    // RAM aliases: only the low word-index bits select the entry
    assign w_idx      = sram_addr[ADDR_W+1:2];
    assign w_off      = {sram_addr[15:2], 2'b00};
    // resetn gate keeps a write presented during reset from landing in RAM
    assign w_ram_wr   = resetn && sram_en && !w_mmio_hit && (sram_we != 4'b0000);
    assign w_mmio_wr  = sram_en && w_mmio_hit && (sram_we != 4'b0000);
    assign w_mem_word = r_mem[w_idx];

`ifdef SRAM_RESP_TIMER_EN
    logic [31:0] r_timer;

    // Free-running timer; a full-word write loads wdata and counts this cycle,
    // so the cycle after the write already shows wdata+1
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_timer <= '0;
        else if (w_mmio_wr && w_off == OFF_TIMER && sram_we == 4'b1111)
            r_timer <= sram_wdata + 32'd1;
        else
            r_timer <= r_timer + 32'd1;
    end

    assign w_timer_rd = r_timer;
`else
    assign w_timer_rd = '0;
`endif

    // RAM byte-lane writes; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (w_ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (sram_we[i])
                    r_mem[w_idx][8*i +: 8] <= sram_wdata[8*i +: 8];
            end
        end
    end

    // Read mux over pre-write state, which gives read-first behaviour
    always_comb begin
        w_rd_word = '0;
        if (!w_mmio_hit) begin
            w_rd_word = w_mem_word;
        end else begin
            case (w_off)
                OFF_LED:    w_rd_word = {16'h0000, r_led};
                OFF_SWITCH: w_rd_word = {24'h000000, r_sw2};
                OFF_SCR:    w_rd_word = r_scratch;
                OFF_TIMER:  w_rd_word = w_timer_rd;
                OFF_WCOUNT: w_rd_word = r_wcount;
                default:    w_rd_word = '0;
            endcase
        end
    end

    // Read data register: loads on every access, holds otherwise
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_rdata <= '0;
        else if (sram_en)
            r_rdata <= w_rd_word;
    end

    // LED and SCRATCH byte-enabled writes
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_led     <= '0;
            r_scratch <= '0;
        end else if (w_mmio_wr) begin
            if (w_off == OFF_LED) begin
                if (sram_we[0]) r_led[7:0]  <= sram_wdata[7:0];
                if (sram_we[1]) r_led[15:8] <= sram_wdata[15:8];
            end
            if (w_off == OFF_SCR) begin
                for (int i = 0; i < 4; i++) begin
                    if (sram_we[i])
                        r_scratch[8*i +: 8] <= sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // RAM write counter; wraps naturally, MMIO writes are not counted
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_wcount <= '0;
        else if (w_ram_wr)
            r_wcount <= r_wcount + 32'd1;
    end

    // Two-flop synchroniser for the asynchronous switch inputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sw1 <= '0;
            r_sw2 <= '0;
        end else begin
            r_sw1 <= switch_in;
            r_sw2 <= r_sw1;
        end
    end

    assign sram_rdata = r_rdata;
    assign led        = r_led;

endmodule

// File: tb/tb_sram_resp_confreg.sv
// Self-checking bench for sram_resp_confreg: scoreboard queue of expected
// read data, pushed at drive time and popped when rdata becomes valid.
module tb_sram_resp_confreg;

    localparam logic [31:0] BASE = 32'hbfaf_0000;
    localparam logic [31:0] W1   = 32'h1c00_0100;
    localparam logic [31:0] W2   = 32'h1c00_0200;
    localparam logic [31:0] W3   = 32'h1c00_0300;

    logic        clk;
    logic        resetn;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic [15:0] led;
    logic [7:0]  switch_in;

    int          checks;
    int          failures;
    int          m_wcount;
    logic [31:0] q[$];

    sram_resp_confreg dut (
        .clk        (clk),
        .resetn     (resetn),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .led        (led),
        .switch_in  (switch_in)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One bus cycle: inputs set 1 time unit after a posedge, returns 1 unit
    // after the next posedge so rdata of this access is observable.
    task automatic cyc(input logic en, input logic [3:0] we,
                       input logic [31:0] a, input logic [31:0] d);
        sram_en    = en;
        sram_we    = we;
        sram_addr  = a;
        sram_wdata = d;
        if (resetn && en && we != 4'b0000 && (a & 32'hffff_0000) != BASE)
            m_wcount++;
        @(posedge clk);
        #1;
        sram_en = 1'b0;
        sram_we = 4'b0000;
    endtask

    task automatic test_reset();
        resetn    = 1'b1;
        sram_en   = 1'b0;
        sram_we   = 4'b0000;
        sram_addr = '0;
        sram_wdata = '0;
        switch_in = 8'h00;
        #1 resetn = 1'b0;
        #3;
        checks++;
        if (sram_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata: got %h want %h", sram_rdata, 32'h0);
        end
        checks++;
        if (led !== 16'h0) begin
            failures++;
            $display("FAIL reset_led: got %h want %h", led, 16'h0);
        end
        @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic test_ram();
        logic [31:0] exp;
        // write then read
        cyc(1'b1, 4'hf, W1, 32'hdeadbeef);
        q.push_back(32'hdeadbeef);
        cyc(1'b1, 4'h0, W1, 32'h0);
        exp = q.pop_front();
        checks++;
        if (sram_rdata !== exp) begin
            failures++;
            $display("FAIL ram_rw: got %h want %h", sram_rdata, exp);
        end
        // idle cycle: rdata holds
        cyc(1'b0, 4'h0, W2, 32'h0);
        checks++;
        if (sram_rdata !== 32'hdeadbeef) begin
            failures++;
            $display("FAIL rdata_hold: got %h want %h", sram_rdata, 32'hdeadbeef);
        end
        // byte-lane write
        cyc(1'b1, 4'b0010, W1, 32'h0000aa00);
        q.push_back(32'hdeadaaef);
        cyc(1'b1, 4'h0, W1, 32'h0);
        exp = q.pop_front();
        checks++;
        if (sram_rdata !== exp) begin
            failures++;
            $display("FAIL byte_write: got %h want %h", sram_rdata, exp);
        end
        // we with en=0 must not write
        cyc(1'b0, 4'hf, W1, 32'h55555555);
        q.push_back(32'hdeadaaef);
        cyc(1'b1, 4'h0, W1, 32'h0);
        exp = q.pop_front();
        checks++;
        if (sram_rdata !== exp) begin
            failures++;
            $display("FAIL we_no_en: got %h want %h", sram_rdata, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        cyc(1'b1, 4'hf, W2, 32'h22222222);
        // read-during-write returns the old word
        q.push_back(32'h22222222);
        cyc(1'b1, 4'hf, W2, 32'h11111111);
        exp = q.pop_front();
        checks++;
        if (sram_rdata !== exp) begin
            failures++;
            $display("FAIL rdw_old: got %h want %h", sram_rdata, exp);
        end
        q.push_back(32'h11111111);
        cyc(1'b1, 4'h0, W2, 32'h0);
        exp = q.pop_front();
        checks++;
        if (sram_rdata !== exp) begin
            failures++;
            $display("FAIL rdw_new: got %h want %h", sram_rdata, exp);
        end
        // alias: index wraps above 2^12 words
        cyc(1'b1, 4'hf, W3, 32'h3c3c5a5a);
        q.push_back(32'h3c3c5a5a);
        cyc(1'b1, 4'h0, W3 + 32'h0000_4000, 32'h0);
        exp = q.pop_front();
        checks++;
        if (sram_rdata !== exp) begin
            failures++;
            $display("FAIL alias: got %h want %h", sram_rdata, exp);
        end
    endtask

    task automatic test_mmio();
        logic [31:0] exp;
        cyc(1'b1, 4'hf, BASE, 32'h0001abcd);
        checks++;
        if (led !== 16'habcd) begin
            failures++;
            $display("FAIL led_out: got %h want %h", led, 16'habcd);
        end
        q.push_back(32'h0000abcd);
        cyc(1'b1, 4'h0, BASE, 32'h0);
        exp = q.pop_front();
        checks++;
        if (sram_rdata !== exp) begin
            failures++;
            $display("FAIL led_read: got %h want %h", sram_rdata, exp);
        end
        // scratch full then partial write
        cyc(1'b1, 4'hf, BASE + 32'h8, 32'h12345678);
        cyc(1'b1, 4'b0100, BASE + 32'h8, 32'h00ab0000);
        // same-cycle write and read returns the old value
        q.push_back(32'h12ab5678);
        cyc(1'b1, 4'hf, BASE + 32'h8, 32'hcafef00d);
        exp = q.pop_front();
        checks++;
        if (sram_rdata !== exp) begin
            failures++;
            $display("FAIL scratch_rdw: got %h want %h", sram_rdata, exp);
        end
        q.push_back(32'hcafef00d);
        cyc(1'b1, 4'h0, BASE + 32'h8, 32'h0);
        exp = q.pop_front();
        checks++;
        if (sram_rdata !== exp) begin
            failures++;
            $display("FAIL scratch_read: got %h want %h", sram_rdata, exp);
        end
        // switch through the synchroniser
        switch_in = 8'h5a;
        cyc(1'b0, 4'h0, 32'h0, 32'h0);
        cyc(1'b0, 4'h0, 32'h0, 32'h0);
        q.push_back(32'h0000005a);
        cyc(1'b1, 4'h0, BASE + 32'h4, 32'h0);
        exp = q.pop_front();
        checks++;
        if (sram_rdata !== exp) begin
            failures++;
            $display("FAIL switch: got %h want %h", sram_rdata, exp);
        end
        // unmapped offset: writes ignored, reads zero
        cyc(1'b1, 4'hf, BASE + 32'h20, 32'hffffffff);
        q.push_back(32'h0);
        cyc(1'b1, 4'h0, BASE + 32'h20, 32'h0);
        exp = q.pop_front();
        checks++;
        if (sram_rdata !== exp) begin
            failures++;
            $display("FAIL unmapped: got %h want %h", sram_rdata, exp);
        end
    endtask

    task automatic test_counters();
        logic [31:0] exp;
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 4'hf, W3 + 32'h10 + 32'(i*4), 32'(i));
        q.push_back(32'(m_wcount));
        cyc(1'b1, 4'h0, BASE + 32'h10, 32'h0);
        exp = q.pop_front();
        checks++;
        if (sram_rdata !== exp) begin
            failures++;
            $display("FAIL wcount: got %h want %h", sram_rdata, exp);
        end
        // timer: write, one idle cycle, read
        cyc(1'b1, 4'hf, BASE + 32'hc, 32'hffff_fffe);
        cyc(1'b0, 4'h0, 32'h0, 32'h0);
`ifdef SRAM_RESP_TIMER_EN
        q.push_back(32'h0000_0000);
`else
        q.push_back(32'h0000_0000);
`endif
        cyc(1'b1, 4'h0, BASE + 32'hc, 32'h0);
        exp = q.pop_front();
        checks++;
        if (sram_rdata !== exp) begin
            failures++;
            $display("FAIL timer_wrap: got %h want %h", sram_rdata, exp);
        end
`ifdef SRAM_RESP_TIMER_EN
        // partial write ignored; timer keeps running (wrapped 0 then +2)
        cyc(1'b1, 4'b0001, BASE + 32'hc, 32'h0000_00ff);
        q.push_back(32'h0000_0002);
`else
        q.push_back(32'h0000_0000);
`endif
        cyc(1'b1, 4'h0, BASE + 32'hc, 32'h0);
        exp = q.pop_front();
        checks++;
        if (sram_rdata !== exp) begin
            failures++;
            $display("FAIL timer_run: got %h want %h", sram_rdata, exp);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp;
        checks++;
        if (led !== 16'habcd) begin
            failures++;
            $display("FAIL led_pre_reset: got %h want %h", led, 16'habcd);
        end
        // read in flight, then async reset between edges
        sram_en   = 1'b1;
        sram_we   = 4'h0;
        sram_addr = W1;
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (sram_rdata !== 32'h0) begin
            failures++;
            $display("FAIL async_rdata: got %h want %h", sram_rdata, 32'h0);
        end
        checks++;
        if (led !== 16'h0) begin
            failures++;
            $display("FAIL async_led: got %h want %h", led, 16'h0);
        end
        m_wcount = 0;
        @(posedge clk);
        #1;
        checks++;
        if (sram_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_drop: got %h want %h", sram_rdata, 32'h0);
        end
        sram_en = 1'b0;
        resetn  = 1'b1;
        q.push_back(32'hdeadaaef);
        cyc(1'b1, 4'h0, W1, 32'h0);
        exp = q.pop_front();
        checks++;
        if (sram_rdata !== exp) begin
            failures++;
            $display("FAIL ram_kept: got %h want %h", sram_rdata, exp);
        end
        q.push_back(32'h0);
        cyc(1'b1, 4'h0, BASE + 32'h8, 32'h0);
        exp = q.pop_front();
        checks++;
        if (sram_rdata !== exp) begin
            failures++;
            $display("FAIL scratch_reset: got %h want %h", sram_rdata, exp);
        end
        q.push_back(32'(m_wcount));
        cyc(1'b1, 4'h0, BASE + 32'h10, 32'h0);
        exp = q.pop_front();
        checks++;
        if (sram_rdata !== exp) begin
            failures++;
            $display("FAIL wcount_reset: got %h want %h", sram_rdata, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_wcount = 0;
        test_reset();
        test_ram();
        test_back_to_back();
        test_mmio();
        test_counters();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
